trace_capture_engine: RTL and testbench

Parametrised on-chip-sensor trace recorder, successor to the fixed 1024×8 capture/readout logic in the sensor top level. Stores decoded sensor samples in a circular buffer with a programmable pre-trigger window, decimation and start/done markers. Serialises the stored trace as bytes through a valid/done handshake to the UART transmitter. Sits between tdc_decode and uart_tx. Single clock domain: the sensor clock.

---
 rtl/trace_capture_engine.sv | 189 ++++++++++++++++++
 tb/tb_trace_capture_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_engine.sv
// Sensor trace recorder: circular capture with pre-trigger window, decimation
// and start/done markers, then byte-serial readout to a UART transmitter.
module trace_capture_engine #(
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MARK_START = 250,
  parameter int unsigned MARK_DONE  = 253
) (
  input  logic                clk,
  input  logic                c10_resetn,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                arm_i,
  input  logic                trig_i,
  input  logic                done_i,
  input  logic [ADDR_W-1:0]   pre_i,
  input  logic [7:0]          decim_i,
  input  logic                rd_start_i,
  output logic [7:0]          tx_byte_o,
  output logic                tx_dv_o,
  input  logic                tx_done_i,
  output logic                busy_o,
  output logic                ready_o,
  output logic                trig_early_o
);

  localparam int unsigned NB    = SAMPLE_W / 8;
  localparam int unsigned BI_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREFILL, S_WAIT_TRIG, S_CAPTURE, S_READY, S_RD_FETCH, S_RD_SEND, S_RD_WAIT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pre_q, fill_cnt, wr_ptr, trig_ptr, rd_ptr;
  logic [7:0]          decim_q, decim_cnt;
  logic [CNT_W-1:0]    post_cnt, samples_left;
  logic [BI_W-1:0]     byte_idx;
  logic                done_sticky, start_pend;
  logic [SAMPLE_W-1:0] ram [DEPTH];
  logic [SAMPLE_W-1:0] rd_q;

  logic                capturing, strobe, mark_start, mark_done;
  logic [SAMPLE_W-1:0] wr_data;
  logic [CNT_W-1:0]    post_total;

  // Write strobe and stored value; start marker outranks done marker
  always_comb begin
    capturing  = (state == S_PREFILL) || (state == S_WAIT_TRIG) || (state == S_CAPTURE);
    strobe     = capturing && (decim_cnt == 8'd0);
    mark_start = start_pend || ((state == S_WAIT_TRIG) && trig_i);
    mark_done  = done_sticky || done_i;
    if (mark_start)     wr_data = SAMPLE_W'(MARK_START);
    else if (mark_done) wr_data = SAMPLE_W'(MARK_DONE);
    else                wr_data = sample_i;
    post_total = CNT_W'(DEPTH) - CNT_W'(pre_q);
  end

  // Trace storage: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (strobe) ram[wr_ptr] <= wr_data;
    if (state == S_RD_FETCH) rd_q <= ram[rd_ptr];
  end

  always_ff @(posedge clk or negedge c10_resetn) begin
    if (!c10_resetn) begin
      state        <= S_IDLE;
      pre_q        <= '0;
      fill_cnt     <= '0;
      wr_ptr       <= '0;
      trig_ptr     <= '0;
      rd_ptr       <= '0;
      decim_q      <= '0;
      decim_cnt    <= '0;
      post_cnt     <= '0;
      samples_left <= '0;
      byte_idx     <= '0;
      done_sticky  <= 1'b0;
      start_pend   <= 1'b0;
      tx_byte_o    <= '0;
      tx_dv_o      <= 1'b0;
      busy_o       <= 1'b0;
      ready_o      <= 1'b0;
      trig_early_o <= 1'b0;
    end else begin
      tx_dv_o <= 1'b0;

      if (capturing) begin
        decim_cnt <= (decim_cnt == decim_q) ? 8'd0 : decim_cnt + 8'd1;
        if (strobe) begin
          wr_ptr      <= wr_ptr + 1'b1;
          done_sticky <= 1'b0;
          start_pend  <= 1'b0;
        end else begin
          done_sticky <= done_sticky | done_i;
        end
      end

      case (state)
        S_IDLE: begin
          if (arm_i) begin
            pre_q        <= pre_i;
            decim_q      <= decim_i;
            decim_cnt    <= '0;
            fill_cnt     <= '0;
            done_sticky  <= 1'b0;
            start_pend   <= 1'b0;
            trig_early_o <= 1'b0;
            busy_o       <= 1'b1;
            state        <= (pre_i == '0) ? S_WAIT_TRIG : S_PREFILL;
          end
        end
        S_PREFILL: begin
          if (trig_i) trig_early_o <= 1'b1;
          if (strobe) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (ADDR_W'(fill_cnt + 1'b1) == pre_q) state <= S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (trig_i) begin
            trig_ptr <= wr_ptr;
            if (strobe) begin
              // The trigger-cycle marker write is the first post-trigger sample
              post_cnt <= post_total - CNT_W'(1);
              if (post_total == CNT_W'(1)) begin
                busy_o  <= 1'b0;
                ready_o <= 1'b1;
                state   <= S_READY;
              end else begin
                state <= S_CAPTURE;
              end
            end else begin
              post_cnt   <= post_total;
              start_pend <= 1'b1;
              state      <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (strobe) begin
            post_cnt <= post_cnt - CNT_W'(1);
            if (post_cnt == CNT_W'(1)) begin
              busy_o  <= 1'b0;
              ready_o <= 1'b1;
              state   <= S_READY;
            end
          end
        end
        S_READY: begin
          if (rd_start_i) begin
            rd_ptr       <= trig_ptr - pre_q;
            samples_left <= CNT_W'(DEPTH);
            busy_o       <= 1'b1;
            ready_o      <= 1'b0;
            state        <= S_RD_FETCH;
          end
        end
        S_RD_FETCH: begin
          byte_idx <= BI_W'(NB - 1);
          state    <= S_RD_SEND;
        end
        S_RD_SEND: begin
          tx_byte_o <= rd_q[8*int'(byte_idx) +: 8];
          tx_dv_o   <= 1'b1;
          state     <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (tx_done_i) begin
            if (byte_idx != '0) begin
              byte_idx <= byte_idx - 1'b1;
              state    <= S_RD_SEND;
            end else if (samples_left == CNT_W'(1)) begin
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end else begin
              rd_ptr       <= rd_ptr + 1'b1;
              samples_left <= samples_left - CNT_W'(1);
              state        <= S_RD_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture_engine.sv
// Bench for trace_capture_engine: randomized captures checked against a
// write-stream model of the trace, plus a 16-bit sample instance.
module tb_trace_capture_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample, decim;
  logic       arm, trig, done, rd_start, tx_done;
  logic [3:0] pre;
  logic [7:0] tx_byte;
  logic       tx_dv, busy, ready, early;

  logic [15:0] sample_w;
  logic        arm_w, trig_w, rd_start_w;
  logic [2:0]  pre_w;
  logic [7:0]  tx_byte_w;
  logic        tx_dv_w, busy_w, ready_w, early_w;

  logic       sel_w;
  logic [7:0] cur_byte;
  logic       cur_dv, cur_busy, cur_ready;
  assign cur_byte  = sel_w ? tx_byte_w : tx_byte;
  assign cur_dv    = sel_w ? tx_dv_w   : tx_dv;
  assign cur_busy  = sel_w ? busy_w    : busy;
  assign cur_ready = sel_w ? ready_w   : ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  trace_capture_engine #(.SAMPLE_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .c10_resetn(rst_n), .sample_i(sample), .arm_i(arm), .trig_i(trig),
    .done_i(done), .pre_i(pre), .decim_i(decim), .rd_start_i(rd_start),
    .tx_byte_o(tx_byte), .tx_dv_o(tx_dv), .tx_done_i(tx_done),
    .busy_o(busy), .ready_o(ready), .trig_early_o(early));

  trace_capture_engine #(.SAMPLE_W(16), .DEPTH(8), .ADDR_W(3)) dut_w (
    .clk(clk), .c10_resetn(rst_n), .sample_i(sample_w), .arm_i(arm_w), .trig_i(trig_w),
    .done_i(done), .pre_i(pre_w), .decim_i(decim), .rd_start_i(rd_start_w),
    .tx_byte_o(tx_byte_w), .tx_dv_o(tx_dv_w), .tx_done_i(tx_done),
    .busy_o(busy_w), .ready_o(ready_w), .trig_early_o(early_w));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive one capture on the 8-bit instance; the model records every stored
  // value in order and the expected trace is the DEPTH values ending with the
  // last write, starting p writes before the start marker.
  task automatic capture_main(input string name, input int p, input int d, input int trig_at,
                              input int early_at, input int done_at, input bit rnd, input bit ramp);
    int cw, t;
    bit acc, ps, pd, exp_early, fin;
    logic [7:0] s;
    logic [7:0] w[$];
    cw = (p == 0) ? 0 : (p - 1) * (d + 1) + 1;
    pre = 4'(p); decim = 8'(d); arm = 1'b1;
    step;
    arm = 1'b0;
    checks++;
    if (busy !== 1'b1 || early !== 1'b0)
      $display("FAIL %s arm: busy=%b early=%b want busy=1 early=0", name, busy, early);
    if (busy !== 1'b1 || early !== 1'b0) errors++;
    acc = 0; ps = 0; pd = 0; exp_early = 0; fin = 0; t = -1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      s      = ramp ? 8'(c + 1) : 8'($urandom);
      sample = s;
      trig   = (c == trig_at) || (c == early_at) || (rnd && ($urandom % 9 == 0));
      done   = (c == done_at) || (rnd && ($urandom % 11 == 0));
      if (trig) begin
        if (c < cw) exp_early = 1;
        else if (!acc) begin acc = 1; ps = 1; end
      end
      if (done) pd = 1;
      if (c % (d + 1) == 0) begin
        if (ps) begin t = w.size(); w.push_back(8'd250); ps = 0; end
        else if (pd) w.push_back(8'd253);
        else w.push_back(s);
        pd = 0;
      end
      step;
      checks++;
      if (t >= 0 && w.size() == t + 16 - p) begin
        fin = 1;
        if (ready !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s ready: ready=%b busy=%b want 1/0", name, ready, busy);
        end
      end else if (busy !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy c=%0d: busy=%b ready=%b want 1/0", name, c, busy, ready);
      end
    end
    trig = 1'b0; done = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: capture never completed, want ready", name);
    end
    checks++;
    if (early !== exp_early) begin
      errors++;
      $display("FAIL %s trig_early: got %b want %b", name, early, exp_early);
    end
    exp_q.delete();
    if (fin) for (int i = 0; i < 16; i++) exp_q.push_back(w[t - p + i]);
  endtask

  // Read the trace out and compare bytes; abort_after>0 resets mid-readout
  task automatic readout(input string name, input bit wide, input int abort_after);
    bit seen;
    sel_w = wide;
    if (wide) rd_start_w = 1'b1; else rd_start = 1'b1;
    step;
    rd_start = 1'b0; rd_start_w = 1'b0;
    checks++;
    if (cur_busy !== 1'b1 || cur_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s rd_start: busy=%b ready=%b want 1/0", name, cur_busy, cur_ready);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (cur_dv === 1'b1) seen = 1;
        else step;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL %s byte%0d: no tx_dv within 20 cycles, want strobe", name, i);
        return;
      end
      checks++;
      if (cur_byte !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte%0d: got %02h want %02h", name, i, cur_byte, exp_q[i]);
      end
      if (abort_after == i + 1) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_byte !== 8'h00 || tx_dv !== 1'b0 || busy !== 1'b0 || ready !== 1'b0 || early !== 1'b0) begin
          errors++;
          $display("FAIL %s reset: byte=%02h dv=%b busy=%b ready=%b early=%b want all 0",
                   name, tx_byte, tx_dv, busy, ready, early);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step;
        return;
      end
      step;
      checks++;
      if (cur_dv !== 1'b0) begin
        errors++;
        $display("FAIL %s dv_width byte%0d: dv=%b want 0", name, i, cur_dv);
      end
      repeat ($urandom_range(0, 2)) begin
        step;
        checks++;
        if (cur_dv !== 1'b0) begin
          errors++;
          $display("FAIL %s dv_extra byte%0d: dv=%b want 0", name, i, cur_dv);
        end
      end
      tx_done = 1'b1;
      step;
      tx_done = 1'b0;
    end
    checks++;
    if (cur_busy !== 1'b0 || cur_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s end: busy=%b ready=%b want 0/0", name, cur_busy, cur_ready);
    end
    sel_w = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) step;
    checks++;
    if (tx_byte !== 8'h00 || tx_dv !== 1'b0 || busy !== 1'b0 || ready !== 1'b0 || early !== 1'b0) begin
      errors++;
      $display("FAIL reset: byte=%02h dv=%b busy=%b ready=%b early=%b want all 0",
               tx_byte, tx_dv, busy, ready, early);
    end
    checks++;
    if (tx_byte_w !== 8'h00 || tx_dv_w !== 1'b0 || busy_w !== 1'b0 || ready_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_wide: byte=%02h dv=%b busy=%b ready=%b want all 0",
               tx_byte_w, tx_dv_w, busy_w, ready_w);
    end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_basic;
    capture_main("basic", 0, 0, 5, -1, 9, 0, 1);
    readout("basic", 0, 0);
  endtask

  task automatic test_pretrigger;
    capture_main("pretrig", 4, 0, 9, -1, -1, 0, 1);
    readout("pretrig", 0, 0);
  endtask

  task automatic test_early_trigger;
    capture_main("early", 8, 0, 12, 3, -1, 0, 1);
    readout("early", 0, 0);
  endtask

  task automatic test_decimation;
    capture_main("decim", 2, 3, 6, -1, 13, 0, 1);
    readout("decim", 0, 0);
  endtask

  task automatic test_full_pre;
    capture_main("full_pre", 15, 0, 20, -1, -1, 0, 1);
    readout("full_pre", 0, 0);
  endtask

  task automatic test_wide;
    bit fin;
    int n;
    pre_w = 3'd0; decim = 8'd0; done = 1'b0; sample_w = 16'hA1B2;
    arm_w = 1'b1;
    step;
    arm_w = 1'b0;
    fin = 0; n = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      trig_w = (c == 2);
      if (c >= 2) n++;
      step;
      if (n == 8) begin
        fin = 1;
        checks++;
        if (ready_w !== 1'b1 || busy_w !== 1'b0) begin
          errors++;
          $display("FAIL wide ready: ready=%b busy=%b want 1/0", ready_w, busy_w);
        end
      end
    end
    trig_w = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'd250);
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hB2);
    end
    readout("wide", 1, 0);
  endtask

  task automatic test_reset_mid_readout;
    capture_main("abort", 3, 1, 10, -1, -1, 0, 0);
    readout("abort", 0, 3);
    capture_main("after_reset", 0, 0, 4, -1, 7, 0, 0);
    readout("after_reset", 0, 0);
  endtask

  task automatic test_random;
    int p, d, cw;
    for (int it = 0; it < 5; it++) begin
      p  = $urandom_range(0, 15);
      d  = $urandom_range(0, 3);
      cw = (p == 0) ? 0 : (p - 1) * (d + 1) + 1;
      capture_main("random", p, d, cw + $urandom_range(0, 20),
                   (cw > 0) ? $urandom_range(0, cw - 1) : -1, -1, 1, 0);
      readout("random", 0, 0);
    end
  endtask

  initial begin
    sel_w = 1'b0;
    sample = '0; decim = '0; arm = 0; trig = 0; done = 0; rd_start = 0; tx_done = 0; pre = '0;
    sample_w = '0; arm_w = 0; trig_w = 0; rd_start_w = 0; pre_w = '0;
    test_reset;
    test_basic;
    test_pretrigger;
    test_early_trigger;
    test_decimation;
    test_full_pre;
    test_wide;
    test_reset_mid_readout;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
